// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants for the memory-mapped UART transmitter:
//                register offsets, STATUS bit positions, TX FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Word offsets of the registers relative to BASE_ADDR
  localparam logic [15:0] c_OFF_DATA   = 16'd0;
  localparam logic [15:0] c_OFF_STATUS = 16'd1;
  localparam logic [15:0] c_OFF_DROPS  = 16'd2;
  localparam logic [15:0] c_NUM_REGS   = 16'd3;

  // STATUS register bit positions
  localparam int c_STAT_FULL    = 0;
  localparam int c_STAT_EMPTY   = 1;
  localparam int c_STAT_ACTIVE  = 2;
  localparam int c_STAT_CNT_LSB = 4;
  localparam int c_STAT_CNT_W   = 4;

  // Serial engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous byte FIFO with push/pop, full/empty and an
//                occupancy count. DEPTH must be a power of two, >= 2, so the
//                pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

  logic [7:0]      mem_q [DEPTH];
  logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0] count_q,  count_d;
  logic            w_do_push;
  logic            w_do_pop;

  assign full_o    = (count_q == c_FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  // Next pointer and occupancy values; simultaneous push+pop leaves count alone
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty so it carries no reset
  always_ff @(posedge clock) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_mmio
//  Description : Memory-mapped 8N1 UART transmitter. DATA stores fill a byte
//                FIFO, a serial engine drains it onto tx. STATUS and DROPS
//                are readable combinationally for single-cycle CPU loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [15:0] address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        select,
  output logic        tx,
  output logic        busy
);

  localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);

  // Bus decode
  logic [15:0] w_offset;
  logic        w_hit_data;
  logic        w_hit_status;
  logic        w_hit_drops;

  // FIFO interface
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic [7:0]         w_fifo_rdata;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [c_CNT_W-1:0] w_fifo_count;

  // Engine state
  tx_state_e           state_q;
  logic [c_BAUD_W-1:0] baud_q;
  logic [2:0]          bit_q;
  logic [7:0]          shift_q;
  logic                tx_q;
  logic                w_tx_active;
  logic                w_baud_last;

  // Drop counter
  logic [7:0]  drops_q, drops_d;
  logic [15:0] w_status;

  // Only the low byte of a store is transmitted
  logic w_unused_hi;
  assign w_unused_hi = &{1'b0, write_data[15:8]};

  // Offset arithmetic keeps the window check correct for any BASE_ADDR
  assign w_offset     = address - BASE_ADDR;
  assign select       = (w_offset < c_NUM_REGS);
  assign w_hit_data   = (w_offset == c_OFF_DATA);
  assign w_hit_status = (w_offset == c_OFF_STATUS);
  assign w_hit_drops  = (w_offset == c_OFF_DROPS);

  // Full is judged on the pre-edge count, so a same-edge pop never rescues a push
  assign w_push = write_enable && w_hit_data && !w_fifo_full;
  assign w_drop = write_enable && w_hit_data && w_fifo_full;

  assign w_baud_last = (baud_q == c_BAUD_LAST);
  assign w_tx_active = (state_q != ST_IDLE);
  assign w_pop       = !w_fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_STOP) && w_baud_last));

  assign tx   = tx_q;
  assign busy = !w_fifo_empty || w_tx_active;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (w_push),
    .wdata_i (write_data[7:0]),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  // Drop counter: a DROPS store clears it, a rejected DATA store bumps it up to 255
  always_comb begin
    drops_d = drops_q;
    if (write_enable && w_hit_drops) begin
      drops_d = 8'h00;
    end else if (w_drop && (drops_q != 8'hFF)) begin
      drops_d = drops_q + 8'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge clock) begin
    if (reset) drops_q <= 8'h00;
    else       drops_q <= drops_d;
  end

  // STATUS word assembly; count is truncated or zero-extended to its 4-bit field
  always_comb begin
    w_status = 16'h0000;
    w_status[c_STAT_FULL]   = w_fifo_full;
    w_status[c_STAT_EMPTY]  = w_fifo_empty;
    w_status[c_STAT_ACTIVE] = w_tx_active;
    w_status[c_STAT_CNT_LSB +: c_STAT_CNT_W] = c_STAT_CNT_W'(w_fifo_count);
  end

  // Register read mux; zero outside the window and for DATA
  always_comb begin
    read_data = 16'h0000;
    if (select) begin
      if (w_hit_status)     read_data = w_status;
      else if (w_hit_drops) read_data = {8'h00, drops_q};
    end
  end

  // Serial engine: tx_q is loaded with the level of the bit period being entered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          bit_q  <= 3'd0;
          if (!w_fifo_empty) begin
            shift_q <= w_fifo_rdata;
            state_q <= ST_START;
            tx_q    <= 1'b0;
          end else begin
            tx_q <= 1'b1;
          end
        end
        ST_START: begin
          if (w_baud_last) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + c_BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (w_baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + c_BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (w_baud_last) begin
            baud_q <= '0;
            bit_q  <= 3'd0;
            // Chain straight into the next start bit when more data is waiting
            if (!w_fifo_empty) begin
              shift_q <= w_fifo_rdata;
              state_q <= ST_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + c_BAUD_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          baud_q  <= '0;
          bit_q   <= 3'd0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_mmio
//  Description : Self-checking bench for uart_tx_mmio with a frame-level
//                reference model (byte queue plus frame countdown).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clock        = 1'b0;
  logic        reset        = 1'b1;
  logic        write_enable = 1'b0;
  logic [15:0] address      = 16'h0000;
  logic [15:0] write_data   = 16'h0000;
  wire  [15:0] read_data;
  wire         select;
  wire         tx;
  wire         busy;

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .write_enable (write_enable),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .select       (select),
    .tx           (tx),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queued bytes, byte on the line, cycles left in its frame
  byte unsigned m_q[$];
  logic [7:0]   m_cur   = 8'h00;
  int           m_timer = 0;
  int           m_drops = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line level from position within the frame: start, 8 data bits LSB first, stop
  function automatic logic m_tx();
    int p;
    int seg;
    if (m_timer == 0) return 1'b1;
    p   = FRAME - m_timer;
    seg = p / CPB;
    if (seg == 0) return 1'b0;
    if (seg == 9) return 1'b1;
    return m_cur[seg-1];
  endfunction

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    int sz;
    sz = m_q.size();
    s = 16'h0000;
    s[7:4] = 4'(sz);
    s[2]   = (m_timer > 0);
    s[1]   = (sz == 0);
    s[0]   = (sz == DEPTH);
    return s;
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    case (off)
      16'd1:   return m_status();
      16'd2:   return 16'(m_drops);
      default: return 16'h0000;
    endcase
  endfunction

  // One clock: apply inputs, advance the model across the edge, check line outputs
  task automatic step(input logic rst, input logic we, input logic [15:0] a, input logic [15:0] d);
    int          pre;
    bit          pop;
    logic [15:0] off;
    reset        = rst;
    write_enable = we;
    address      = a;
    write_data   = d;
    @(posedge clock);
    if (rst) begin
      m_q.delete();
      m_timer = 0;
      m_drops = 0;
    end else begin
      pre = m_q.size();
      pop = (pre > 0) && (m_timer <= 1);
      if (pop) begin
        m_cur   = m_q.pop_front();
        m_timer = FRAME;
      end else if (m_timer > 0) begin
        m_timer--;
      end
      if (we) begin
        off = a - BASE;
        if (off == 16'd0) begin
          if (pre < DEPTH) m_q.push_back(d[7:0]);
          else if (m_drops < 255) m_drops++;
        end else if (off == 16'd2) begin
          m_drops = 0;
        end
      end
    end
    #1;
    check("tx", 16'(tx), 16'(m_tx()));
    check("busy", 16'(busy), 16'((m_q.size() > 0) || (m_timer > 0)));
  endtask

  // Combinational read between edges
  task automatic rd_check(input logic [15:0] a, input string tag);
    logic [15:0] off;
    reset        = 1'b0;
    write_enable = 1'b0;
    address      = a;
    #1;
    off = a - BASE;
    check({tag, "_sel"}, 16'(select), 16'(off < 16'd3));
    check({tag, "_rd"}, read_data, m_read(a));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  logic [15:0] r_addr;

  initial begin
    // Reset state
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    rd_check(BASE + 16'd1, "rst_status");
    check("rst_status_const", read_data, 16'h0002);
    rd_check(BASE, "rst_data");
    rd_check(BASE + 16'd2, "rst_drops");

    // Single byte: frame of 40 cycles, busy drops at edge 41
    step(1'b0, 1'b1, BASE, 16'h1255);
    idle(40);
    check("single_busy_e40", 16'(busy), 16'h0001);
    idle(1);
    check("single_busy_e41", 16'(busy), 16'h0000);
    rd_check(BASE + 16'd2, "single_drops");
    idle(3);

    // Back-to-back: two frames with no gap, 80 cycles of activity
    step(1'b0, 1'b1, BASE, 16'h0000);
    step(1'b0, 1'b1, BASE, 16'hAAFF);
    idle(79);
    check("b2b_busy_e80", 16'(busy), 16'h0001);
    idle(1);
    check("b2b_busy_e81", 16'(busy), 16'h0000);
    idle(3);

    // Overflow: six stores, exactly one seen full
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, BASE, 16'(32'h30 + i));
    rd_check(BASE + 16'd2, "ovf_drops");
    check("ovf_drops_const", read_data, 16'h0001);
    step(1'b0, 1'b1, BASE + 16'd2, 16'($urandom));
    rd_check(BASE + 16'd2, "ovf_clear");
    check("ovf_clear_const", read_data, 16'h0000);
    idle(210);

    // STATUS polling while busy with a full FIFO
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, BASE, 16'($urandom));
    rd_check(BASE + 16'd1, "poll_status");
    check("poll_status_const", read_data, 16'h0045);
    rd_check(BASE + 16'd3, "poll_out");
    check("poll_out_sel", 16'(select), 16'h0000);
    step(1'b0, 1'b1, BASE + 16'd1, 16'hFFFF);
    rd_check(BASE + 16'd1, "status_wr_ignored");
    idle(210);

    // Reset during data bit 3 with two bytes queued
    step(1'b0, 1'b1, BASE, 16'h00C3);
    step(1'b0, 1'b1, BASE, 16'h0011);
    step(1'b0, 1'b1, BASE, 16'h0022);
    idle(16);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    check("rstmid_tx", 16'(tx), 16'h0001);
    check("rstmid_busy", 16'(busy), 16'h0000);
    rd_check(BASE + 16'd1, "rstmid_status");
    check("rstmid_status_const", read_data, 16'h0002);
    idle(50);

    // DROPS saturation under a sustained flood
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, BASE, 16'($urandom));
    rd_check(BASE + 16'd2, "sat_drops");
    check("sat_drops_const", read_data, 16'h00FF);
    step(1'b0, 1'b1, BASE + 16'd2, 16'h1234);
    rd_check(BASE + 16'd2, "sat_clear");
    idle(220);

    // Randomized traffic across the window and its neighbours
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 6))
        0:       r_addr = BASE - 16'd1;
        1:       r_addr = BASE + 16'd1;
        2:       r_addr = BASE + 16'd2;
        3:       r_addr = BASE + 16'd3;
        default: r_addr = BASE;
      endcase
      if (r == 0)      step(1'b1, 1'b0, 16'h0000, 16'h0000);
      else if (r < 12) step(1'b0, 1'b1, r_addr, 16'($urandom));
      else             step(1'b0, 1'b0, 16'h0000, 16'h0000);
      rd_check(BASE + 16'($urandom_range(0, 4)) - 16'd1, "rand_rd");
    end
    idle(250);
    rd_check(BASE + 16'd1, "final_status");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
